// File: rtl/br_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | br_write_arbiter: round-robin arbiter that gives requester A (ALU) and   |
// | requester B (load) turns at the register bank's single write port.      |
// | The write command is registered, and the module also flags read-after-  |
// | write hazards and counts how many writes reach the bank.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module br_write_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DROP_R0 = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              hazard_1,
  output logic              hazard_2,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [0:0] {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e              prio_q, prio_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_drop;
  logic               hz_en_1, hz_en_2;

  // Grants depend only on valids, stall, reset and priority, never on addr/data.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n && !stall) begin
      if (a_valid && (!b_valid || (prio_q == PRIO_A))) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d   = prio_q;
    sel_addr = a_addr;
    sel_data = a_data;
    if (a_ready) begin
      prio_d = PRIO_B;
    end else if (b_ready) begin
      prio_d   = PRIO_A;
      sel_addr = b_addr;
      sel_data = b_data;
    end
    // A dropped r0 write still completes the handshake and still rotates priority.
    sel_drop   = (DROP_R0 != 0) && (sel_addr == '0);
    wr_en_d    = (a_ready || b_ready) && !sel_drop;
    wr_addr_d  = wr_en_d ? sel_addr : wr_addr_q;
    wr_data_d  = wr_en_d ? sel_data : wr_data_q;
    wr_count_d = wr_count_q + CNT_W'(wr_en_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q     <= PRIO_A;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
    end else begin
      prio_q     <= prio_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  generate
    if (DROP_R0 != 0) begin : g_drop_r0
      assign hz_en_1 = |rd_addr_1;
      assign hz_en_2 = |rd_addr_2;
    end else begin : g_keep_r0
      assign hz_en_1 = 1'b1;
      assign hz_en_2 = 1'b1;
    end
  endgenerate

  // The bank reads on the same negedge it writes, so an issuing write is a hazard too.
  assign hazard_1 = hz_en_1 && ((wr_en_q && (wr_addr_q == rd_addr_1)) ||
                                (a_valid && (a_addr == rd_addr_1)) ||
                                (b_valid && (b_addr == rd_addr_1)));
  assign hazard_2 = hz_en_2 && ((wr_en_q && (wr_addr_q == rd_addr_2)) ||
                                (a_valid && (a_addr == rd_addr_2)) ||
                                (b_valid && (b_addr == rd_addr_2)));

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_br_write_arbiter.sv
`default_nettype none
// Testbench for br_write_arbiter: a reference model predicts grants and hazards,
// and a scoreboard queue holds the writes expected at the bank port.
module tb_br_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_1, rd_addr_2;
  logic              hazard_1, hazard_2;
  logic [CNT_W-1:0]  wr_count;

  br_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_R0(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .hazard_1(hazard_1), .hazard_2(hazard_2), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic              m_prio;      // 0 favours A, 1 favours B
  logic              m_wr_en;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;
  logic [CNT_W-1:0]  m_cnt;
  logic              m_acc_a, m_acc_b;

  function automatic logic model_hz(input logic [ADDR_W-1:0] rd);
    return (rd != 0) && ((m_wr_en && (m_wr_addr == rd)) ||
                         (a_valid && (a_addr == rd)) ||
                         (b_valid && (b_addr == rd)));
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check the registered bank command just after the edge.
  task automatic cycle();
    logic ea, eb, eh1, eh2;
    wr_t  e;
    @(negedge clk);
    ea  = rst_n && !stall && a_valid && (!b_valid || (m_prio == 1'b0));
    eb  = rst_n && !stall && b_valid && (!a_valid || (m_prio == 1'b1));
    eh1 = model_hz(rd_addr_1);
    eh2 = model_hz(rd_addr_2);
    checks++; if (a_ready !== ea) begin errors++; $display("FAIL a_ready: got %0b expected %0b at %0t", a_ready, ea, $time); end
    checks++; if (b_ready !== eb) begin errors++; $display("FAIL b_ready: got %0b expected %0b at %0t", b_ready, eb, $time); end
    checks++; if (hazard_1 !== eh1) begin errors++; $display("FAIL hazard_1: got %0b expected %0b at %0t", hazard_1, eh1, $time); end
    checks++; if (hazard_2 !== eh2) begin errors++; $display("FAIL hazard_2: got %0b expected %0b at %0t", hazard_2, eh2, $time); end
    m_acc_a = ea;
    m_acc_b = eb;
    if (!rst_n) begin
      sb.delete();
      m_prio = 1'b0; m_cnt = '0; m_wr_addr = '0; m_wr_data = '0;
    end else if (ea) begin
      m_prio = 1'b1;
      if (a_addr != 0) sb.push_back('{addr: a_addr, data: a_data});
    end else if (eb) begin
      m_prio = 1'b0;
      if (b_addr != 0) sb.push_back('{addr: b_addr, data: b_data});
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      m_wr_en = 1'b1; m_wr_addr = e.addr; m_wr_data = e.data; m_cnt = m_cnt + 1'b1;
    end else begin
      m_wr_en = 1'b0;
    end
    checks++; if (wr_en !== m_wr_en) begin errors++; $display("FAIL wr_en: got %0b expected %0b at %0t", wr_en, m_wr_en, $time); end
    checks++; if (wr_addr !== m_wr_addr) begin errors++; $display("FAIL wr_addr: got %0d expected %0d at %0t", wr_addr, m_wr_addr, $time); end
    checks++; if (wr_data !== m_wr_data) begin errors++; $display("FAIL wr_data: got %h expected %h at %0t", wr_data, m_wr_data, $time); end
    checks++; if (wr_count !== m_cnt) begin errors++; $display("FAIL wr_count: got %0d expected %0d at %0t", wr_count, m_cnt, $time); end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    rd_addr_1 = '0; rd_addr_2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4;
    repeat (3) cycle();
    checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || wr_count !== '0) begin
      errors++; $display("FAIL reset_state: got en=%0b addr=%0d data=%h cnt=%0d expected all zero", wr_en, wr_addr, wr_data, wr_count);
    end
    rst_n = 1'b1;
    idle_inputs();
    cycle();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    cycle();
    a_valid = 1'b0;
    cycle();
    cycle();
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", wr_count); end
  endtask

  task automatic test_tie();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'hA4;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hB5;
    repeat (4) cycle();
    idle_inputs();
    cycle();
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL tie_count: got %0d expected 4", wr_count); end
  endtask

  task automatic test_drop_r0();
    do_reset();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFF;
    cycle();
    b_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'hA6;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'hB8;
    cycle();
    idle_inputs();
    cycle();
    checks++; if (wr_count !== 16'd1 || wr_addr !== 5'd6) begin
      errors++; $display("FAIL drop_r0: got cnt=%0d addr=%0d expected cnt=1 addr=6", wr_count, wr_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    cycle();
    stall = 1'b1;
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hAA;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hBB;
    repeat (3) cycle();
    stall = 1'b0;
    cycle();
    b_valid = 1'b0;
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic test_hazard();
    do_reset();
    rd_addr_1 = 5'd7; rd_addr_2 = 5'd0;
    stall = 1'b1;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    cycle();
    stall = 1'b0;
    cycle();
    a_valid = 1'b0;
    cycle();
    checks++; if (hazard_1 !== 1'b0) begin errors++; $display("FAIL hazard_clear: got %0b expected 0", hazard_1); end
    cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC12;
    cycle();
    a_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 5'd13; a_data = 32'hD13;
    b_valid = 1'b1; b_addr = 5'd14; b_data = 32'hE14;
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (!a_valid || m_acc_a) begin
        a_valid = $urandom_range(0, 1) == 1;
        a_addr  = ADDR_W'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!b_valid || m_acc_b) begin
        b_valid = $urandom_range(0, 1) == 1;
        b_addr  = ADDR_W'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      stall     = $urandom_range(0, 4) == 0;
      rd_addr_1 = ADDR_W'($urandom_range(0, 7));
      rd_addr_2 = ADDR_W'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_prio = 1'b0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_cnt = '0;
    m_acc_a = 1'b0; m_acc_b = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_drop_r0();
    test_stall();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
